// File: rtl/wb_arbiter.sv
// wb_arbiter: register-file writeback arbiter for the ALU and load/store unit.
// ALU results always win and are never stalled. Load results are buffered in a
// DEPTH-entry FIFO and drained into the register file whenever the ALU is idle.
// Optional build macro WB_LSU_BYPASS_EN: when defined, a load result arriving
// with the queue empty and the ALU idle goes straight to the register-file
// port (latency 1) instead of being enqueued (latency 2).
module wb_arbiter #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       alu_valid,
   input  logic [4:0]                 alu_rd,
   input  logic [31:0]                alu_data,
   input  logic                       lsu_valid,
   output logic                       lsu_ready,
   input  logic [4:0]                 lsu_rd,
   input  logic [31:0]                lsu_data,
   output logic                       rf_we,
   output logic [4:0]                 rf_rd,
   output logic [31:0]                rf_wdata,
   output logic [31:0]                pend_mask,
   output logic [$clog2(DEPTH):0]     q_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // queue bookkeeping
   logic [AW-1:0]    head_q, head_d;
   logic [AW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    q_count_q, q_count_d;
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [31:0]      pend_mask_q, pend_mask_d;

   // queue payload storage (never reset; qualified by valid_q)
   logic [4:0]       mem_rd_q   [DEPTH];
   logic [31:0]      mem_data_q [DEPTH];

   // registered writeback port
   logic             rf_we_q, rf_we_d;
   logic [4:0]       rf_rd_q, rf_rd_d;
   logic [31:0]      rf_wdata_q, rf_wdata_d;

   logic             lsu_hs;
   logic             q_empty;
   logic             bypass;
   logic             push;
   logic             pop;

   // Ready depends only on registered occupancy, so there is no combinational
   // path from lsu_valid or alu_valid back to lsu_ready.
   assign lsu_ready = (q_count_q != CW'(DEPTH));
   assign q_empty   = (q_count_q == '0);
   assign lsu_hs    = lsu_valid && lsu_ready;

`ifdef WB_LSU_BYPASS_EN
   assign bypass = lsu_hs && q_empty && !alu_valid;
`else
   assign bypass = 1'b0;
`endif

   // A bypassed load never touches the queue; ALU has priority over the head.
   assign push = lsu_hs && !bypass;
   assign pop  = !alu_valid && !q_empty;

   // Next-state for pointers, occupancy and per-entry valid bits.
   always_comb begin
      head_d    = head_q;
      tail_d    = tail_q;
      q_count_d = q_count_q;
      valid_d   = valid_q;
      if (pop) begin
         head_d          = head_q + AW'(1);
         valid_d[head_q] = 1'b0;
      end
      if (push) begin
         tail_d          = tail_q + AW'(1);
         valid_d[tail_q] = 1'b1;
      end
      case ({push, pop})
         2'b10:   q_count_d = q_count_q + CW'(1);
         2'b01:   q_count_d = q_count_q - CW'(1);
         default: q_count_d = q_count_q;
      endcase
   end

   // Pending-register mask reflects queue contents after this edge. An entry
   // being pushed this cycle is taken from the input, since storage updates
   // on the same edge.
   always_comb begin
      logic [4:0] ent_rd;
      pend_mask_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (push && (tail_q == AW'(i))) begin
            ent_rd = lsu_rd;
         end else begin
            ent_rd = mem_rd_q[i];
         end
         if (valid_d[i] && (ent_rd != 5'd0)) begin
            pend_mask_d[ent_rd] = 1'b1;
         end
      end
   end

   // Writeback selection: ALU, else queue head, else bypassed load, else idle.
   // Writes to x0 are consumed but never assert the enable.
   always_comb begin
      rf_we_d    = 1'b0;
      rf_rd_d    = rf_rd_q;
      rf_wdata_d = rf_wdata_q;
      if (alu_valid) begin
         rf_we_d    = (alu_rd != 5'd0);
         rf_rd_d    = alu_rd;
         rf_wdata_d = alu_data;
      end else if (!q_empty) begin
         rf_we_d    = (mem_rd_q[head_q] != 5'd0);
         rf_rd_d    = mem_rd_q[head_q];
         rf_wdata_d = mem_data_q[head_q];
      end else if (bypass) begin
         rf_we_d    = (lsu_rd != 5'd0);
         rf_rd_d    = lsu_rd;
         rf_wdata_d = lsu_data;
      end
   end

   // Control state and writeback port registers, asynchronously cleared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q      <= '0;
         tail_q      <= '0;
         q_count_q   <= '0;
         valid_q     <= '0;
         pend_mask_q <= '0;
         rf_we_q     <= 1'b0;
         rf_rd_q     <= '0;
         rf_wdata_q  <= '0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         q_count_q   <= q_count_d;
         valid_q     <= valid_d;
         pend_mask_q <= pend_mask_d;
         rf_we_q     <= rf_we_d;
         rf_rd_q     <= rf_rd_d;
         rf_wdata_q  <= rf_wdata_d;
      end
   end

   // Queue payload write; no reset needed because valid_q gates every use.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_rd_q[tail_q]   <= lsu_rd;
         mem_data_q[tail_q] <= lsu_data;
      end
   end

   assign rf_we     = rf_we_q;
   assign rf_rd     = rf_rd_q;
   assign rf_wdata  = rf_wdata_q;
   assign pend_mask = pend_mask_q;
   assign q_count   = q_count_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter. Expected register-file writes are queued when
// stimulus is applied and retired in order by a monitor on the falling edge.
module tb_wb_arbiter;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        lsu_valid;
   logic        lsu_ready;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic        rf_we;
   logic [4:0]  rf_rd;
   logic [31:0] rf_wdata;
   logic [31:0] pend_mask;
   logic [2:0]  q_count;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wr_t;

   wr_t sb[$];
   int  n_vec = 0;
   int  n_err = 0;

   wb_arbiter #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .alu_valid (alu_valid),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .lsu_valid (lsu_valid),
      .lsu_ready (lsu_ready),
      .lsu_rd    (lsu_rd),
      .lsu_data  (lsu_data),
      .rf_we     (rf_we),
      .rf_rd     (rf_rd),
      .rf_wdata  (rf_wdata),
      .pend_mask (pend_mask),
      .q_count   (q_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
      wr_t w;
      w.rd   = rd;
      w.data = data;
      sb.push_back(w);
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Retire every observed register-file write against the scoreboard.
   always @(negedge clk) begin
      if (rst_n && rf_we) begin
         n_vec++;
         assert (sb.size() != 0) else begin
            n_err++;
            $error("FAIL unexpected_write observed rd=%0d data=%h expected no write", rf_rd, rf_wdata);
         end
         if (sb.size() != 0) begin
            wr_t w;
            w = sb.pop_front();
            check("wr_rd", 32'(rf_rd), 32'(w.rd));
            check("wr_data", rf_wdata, w.data);
         end
      end
   end

   initial begin
      rst_n     = 1'b0;
      alu_valid = 1'b0;
      alu_rd    = '0;
      alu_data  = '0;
      lsu_valid = 1'b0;
      lsu_rd    = '0;
      lsu_data  = '0;
      step();
      step();
      check("rst_rf_we", 32'(rf_we), 32'd0);
      check("rst_rf_rd", 32'(rf_rd), 32'd0);
      check("rst_rf_wdata", rf_wdata, 32'd0);
      check("rst_q_count", 32'(q_count), 32'd0);
      check("rst_pend_mask", pend_mask, 32'd0);
      check("rst_lsu_ready", 32'(lsu_ready), 32'd1);
      rst_n = 1'b1;
      step();

      // ALU write, latency 1
      alu_valid = 1'b1;
      alu_rd    = 5'd5;
      alu_data  = 32'hDEADBEEF;
      expect_wr(5'd5, 32'hDEADBEEF);
      step();
      check("alu_rf_we", 32'(rf_we), 32'd1);
      check("alu_rf_rd", 32'(rf_rd), 32'd5);
      check("alu_rf_wdata", rf_wdata, 32'hDEADBEEF);
      alu_valid = 1'b0;
      step();
      check("idle_rf_we", 32'(rf_we), 32'd0);
      check("idle_rf_rd_hold", 32'(rf_rd), 32'd5);
      check("idle_rf_wdata_hold", rf_wdata, 32'hDEADBEEF);

      // Load into an empty queue with the ALU idle
      lsu_valid = 1'b1;
      lsu_rd    = 5'd7;
      lsu_data  = 32'hA5A5A5A5;
      expect_wr(5'd7, 32'hA5A5A5A5);
      step();
      lsu_valid = 1'b0;
`ifdef WB_LSU_BYPASS_EN
      check("lat_n1_rf_we", 32'(rf_we), 32'd1);
      check("lat_n1_rf_rd", 32'(rf_rd), 32'd7);
      check("lat_n1_q_count", 32'(q_count), 32'd0);
      step();
      check("lat_n2_rf_we", 32'(rf_we), 32'd0);
`else
      check("lat_n1_rf_we", 32'(rf_we), 32'd0);
      check("lat_n1_q_count", 32'(q_count), 32'd1);
      check("lat_n1_pend", pend_mask, 32'h0000_0080);
      step();
      check("lat_n2_rf_we", 32'(rf_we), 32'd1);
      check("lat_n2_rf_rd", 32'(rf_rd), 32'd7);
      check("lat_n2_q_count", 32'(q_count), 32'd0);
      check("lat_n2_pend", pend_mask, 32'd0);
`endif
      step();

      // Load to x0: consumed, never written
      lsu_valid = 1'b1;
      lsu_rd    = 5'd0;
      lsu_data  = 32'h0000_1234;
      step();
      lsu_valid = 1'b0;
      check("x0_a_rf_we", 32'(rf_we), 32'd0);
      check("x0_a_pend", pend_mask, 32'd0);
`ifndef WB_LSU_BYPASS_EN
      check("x0_a_q_count", 32'(q_count), 32'd1);
`endif
      step();
      check("x0_b_rf_we", 32'(rf_we), 32'd0);
      check("x0_b_q_count", 32'(q_count), 32'd0);
      check("x0_b_pend", pend_mask, 32'd0);

      // ALU held busy (writing x0) while five loads are offered
      alu_valid = 1'b1;
      alu_rd    = 5'd0;
      alu_data  = 32'h0;
      for (int i = 1; i <= 4; i++) begin
         lsu_valid = 1'b1;
         lsu_rd    = 5'(i);
         lsu_data  = 32'(32'h100 + i);
         expect_wr(5'(i), 32'(32'h100 + i));
         step();
      end
      lsu_rd   = 5'd5;
      lsu_data = 32'h105;
      expect_wr(5'd5, 32'h105);
      check("full_ready", 32'(lsu_ready), 32'd0);
      check("full_q_count", 32'(q_count), 32'd4);
      // only rd 1..4 are queued; rd 5 is still being refused
      check("full_pend", pend_mask, 32'h0000_001E);
      step();
      step();
      check("starve_q_count", 32'(q_count), 32'd4);
      check("starve_pend", pend_mask, 32'h0000_001E);
      check("starve_ready", 32'(lsu_ready), 32'd0);
      check("starve_rf_we", 32'(rf_we), 32'd0);
      alu_valid = 1'b0;
      step();
      check("drain1_q_count", 32'(q_count), 32'd3);
      check("drain1_ready", 32'(lsu_ready), 32'd1);
      step();
      check("pushpop_q_count", 32'(q_count), 32'd3);
      check("pushpop_pend", pend_mask, 32'h0000_0038);
      lsu_valid = 1'b0;
      step();
      step();
      step();
      check("drained_q_count", 32'(q_count), 32'd0);
      check("drained_pend", pend_mask, 32'd0);
      step();

      // Full queue: one pop raises ready, the held offer refills to four
      alu_valid = 1'b1;
      alu_rd    = 5'd0;
      for (int i = 8; i <= 11; i++) begin
         lsu_valid = 1'b1;
         lsu_rd    = 5'(i);
         lsu_data  = 32'(32'h200 + i);
         expect_wr(5'(i), 32'(32'h200 + i));
         step();
      end
      lsu_rd    = 5'd12;
      lsu_data  = 32'h20C;
      expect_wr(5'd12, 32'h20C);
      alu_valid = 1'b0;
      step();
      check("refill_pop_q_count", 32'(q_count), 32'd3);
      check("refill_pop_ready", 32'(lsu_ready), 32'd1);
      alu_valid = 1'b1;
      step();
      check("refill_q_count", 32'(q_count), 32'd4);
      check("refill_ready", 32'(lsu_ready), 32'd0);
      check("refill_pend", pend_mask, 32'h0000_1E00);
      alu_valid = 1'b0;
      lsu_valid = 1'b0;
      step();
      step();
      step();
      step();
      check("refill_drained", 32'(q_count), 32'd0);
      step();

      // Reset while three entries are queued
      alu_valid = 1'b1;
      alu_rd    = 5'd0;
      for (int i = 20; i <= 22; i++) begin
         lsu_valid = 1'b1;
         lsu_rd    = 5'(i);
         lsu_data  = 32'(32'h300 + i);
         if (i == 22) begin
            alu_rd   = 5'd9;
            alu_data = 32'hCAFE0009;
            expect_wr(5'd9, 32'hCAFE0009);
         end
         step();
      end
      alu_valid = 1'b0;
      lsu_valid = 1'b0;
      check("prerst_q_count", 32'(q_count), 32'd3);
      check("prerst_pend", pend_mask, 32'h0070_0000);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_rf_we", 32'(rf_we), 32'd0);
      check("midrst_rf_rd", 32'(rf_rd), 32'd0);
      check("midrst_rf_wdata", rf_wdata, 32'd0);
      check("midrst_q_count", 32'(q_count), 32'd0);
      check("midrst_pend", pend_mask, 32'd0);
      step();
      step();
      rst_n = 1'b1;
      step();
      check("postrst_ready", 32'(lsu_ready), 32'd1);
      check("postrst_q_count", 32'(q_count), 32'd0);
      step();
      step();
      check("postrst_rf_we", 32'(rf_we), 32'd0);

      n_vec++;
      assert (sb.size() == 0) else begin
         n_err++;
         $error("FAIL sb_empty observed=%0d pending writes expected=0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
